// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, ALU codes, FSM state encoding and instruction
//               field helpers for the stack-based cpu core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction field positions (16-bit instruction word)
    localparam int c_OPC_MSB = 15;
    localparam int c_OPC_LSB = 11;
    localparam int c_IMM_MSB = 10;
    localparam int c_IMM_LSB = 0;

    // Opcodes
    localparam logic [4:0] c_OPC_NOP    = 5'd0;
    localparam logic [4:0] c_OPC_PUSH_I = 5'd1;
    localparam logic [4:0] c_OPC_PUSH   = 5'd2;
    localparam logic [4:0] c_OPC_POP    = 5'd3;
    localparam logic [4:0] c_OPC_ADD    = 5'd4;
    localparam logic [4:0] c_OPC_SUB    = 5'd5;
    localparam logic [4:0] c_OPC_MUL    = 5'd6;
    localparam logic [4:0] c_OPC_DIV    = 5'd7;
    localparam logic [4:0] c_OPC_MOD    = 5'd8;
    localparam logic [4:0] c_OPC_AND    = 5'd9;
    localparam logic [4:0] c_OPC_NAND   = 5'd10;
    localparam logic [4:0] c_OPC_OR     = 5'd11;
    localparam logic [4:0] c_OPC_XOR    = 5'd12;
    localparam logic [4:0] c_OPC_CMP_EQ = 5'd13;
    localparam logic [4:0] c_OPC_NOT    = 5'd14;
    localparam logic [4:0] c_OPC_GOTO   = 5'd15;
    localparam logic [4:0] c_OPC_IF_Z   = 5'd16;
    localparam logic [4:0] c_OPC_CALL   = 5'd20;
    localparam logic [4:0] c_OPC_RET    = 5'd21;
    localparam logic [4:0] c_OPC_HALT   = 5'd31;

    // ALU operation codes presented on op_ALU
    localparam logic [3:0] c_ALU_ADD    = 4'd0;
    localparam logic [3:0] c_ALU_SUB    = 4'd1;
    localparam logic [3:0] c_ALU_MUL    = 4'd2;
    localparam logic [3:0] c_ALU_DIV    = 4'd3;
    localparam logic [3:0] c_ALU_MOD    = 4'd4;
    localparam logic [3:0] c_ALU_AND    = 4'd5;
    localparam logic [3:0] c_ALU_NAND   = 4'd6;
    localparam logic [3:0] c_ALU_OR     = 4'd7;
    localparam logic [3:0] c_ALU_XOR    = 4'd8;
    localparam logic [3:0] c_ALU_CMP_EQ = 4'd9;
    localparam logic [3:0] c_ALU_NOT    = 4'd10;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_POP_B  = 3'd2,
        ST_POP_A  = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_PUSH   = 3'd5,
        ST_EXEC   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    function automatic logic [4:0] get_opc(input logic [15:0] word);
        return word[c_OPC_MSB:c_OPC_LSB];
    endfunction

    function automatic logic [10:0] get_imm(input logic [15:0] word);
        return word[c_IMM_MSB:c_IMM_LSB];
    endfunction

    // Two-operand ALU instructions occupy a contiguous opcode range
    function automatic logic is_binary_alu(input logic [4:0] opc);
        return (opc >= c_OPC_ADD) && (opc <= c_OPC_CMP_EQ);
    endfunction

    // ALU code follows the opcode order of the binary ops; NOT has its own
    function automatic logic [3:0] alu_code(input logic [4:0] opc);
        if (is_binary_alu(opc)) begin
            return 4'(opc - c_OPC_ADD);
        end else if (opc == c_OPC_NOT) begin
            return c_ALU_NOT;
        end else begin
            return c_ALU_ADD;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Control sequencer of the cpu core: state register, next-state
//               decode and Moore strobe generation for memories and stacks.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] fetch_opc,
    input  logic [4:0] ir_opc,
    input  logic       stack_full_operations,
    input  logic       stack_full_subroutines,
    output state_t     state,
    output logic       read_inst_enable,
    output logic       read_data_enable,
    output logic       write_data_enable,
    output logic       stack_push_operations,
    output logic       stack_pop_operations,
    output logic       stack_push_subroutines,
    output logic       stack_pop_subroutines
);

    state_t r_state;
    state_t w_next_state;

    assign state = r_state;

    // State register; reset restarts at FETCH and aborts any instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: DECODE dispatches on the opcode arriving from memory
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: begin
                if (is_binary_alu(fetch_opc)) begin
                    w_next_state = ST_POP_B;
                end else begin
                    case (fetch_opc)
                        c_OPC_PUSH_I, c_OPC_POP, c_OPC_GOTO,
                        c_OPC_IF_Z, c_OPC_CALL, c_OPC_RET: w_next_state = ST_EXEC;
                        c_OPC_PUSH:                        w_next_state = ST_MEM_RD;
                        c_OPC_NOT:                         w_next_state = ST_POP_A;
                        c_OPC_HALT:                        w_next_state = ST_HALT;
                        default:                           w_next_state = ST_FETCH;
                    endcase
                end
            end
            ST_POP_B:  w_next_state = ST_POP_A;
            ST_POP_A:  w_next_state = ST_PUSH;
            ST_MEM_RD: w_next_state = ST_PUSH;
            ST_PUSH:   w_next_state = stack_full_operations ? ST_HALT : ST_FETCH;
            ST_EXEC: begin
                if (((ir_opc == c_OPC_PUSH_I) && stack_full_operations) ||
                    ((ir_opc == c_OPC_CALL) && stack_full_subroutines)) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Strobe decode; pushes into a full stack are suppressed, and every
    // strobe is held low while reset is asserted
    always_comb begin
        read_inst_enable       = 1'b0;
        read_data_enable       = 1'b0;
        write_data_enable      = 1'b0;
        stack_push_operations  = 1'b0;
        stack_pop_operations   = 1'b0;
        stack_push_subroutines = 1'b0;
        stack_pop_subroutines  = 1'b0;
        if (reset) begin
            case (r_state)
                ST_FETCH:  read_inst_enable = 1'b1;
                ST_MEM_RD: read_data_enable = 1'b1;
                ST_POP_B,
                ST_POP_A:  stack_pop_operations = 1'b1;
                ST_PUSH:   stack_push_operations = !stack_full_operations;
                ST_EXEC: begin
                    case (ir_opc)
                        c_OPC_PUSH_I: stack_push_operations = !stack_full_operations;
                        c_OPC_POP: begin
                            write_data_enable    = 1'b1;
                            stack_pop_operations = 1'b1;
                        end
                        c_OPC_IF_Z:   stack_pop_operations   = 1'b1;
                        c_OPC_CALL:   stack_push_subroutines = !stack_full_subroutines;
                        c_OPC_RET:    stack_pop_subroutines  = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
// Module      : cpu
// Description : Multi-cycle stack-based 16-bit core. Holds PC, IR and ALU
//               operand registers; sequencing lives in cpu_control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu
    import cpu_pkg::*;
#(
    parameter int WIDTH_DATA = 16,
    parameter int AWIDTH     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_DATA-1:0] instruction,
    output logic [AWIDTH-1:0]     address_memory_inst,
    output logic                  read_inst_enable,
    output logic [WIDTH_DATA-1:0] memory_data_out,
    input  logic [WIDTH_DATA-1:0] memory_data_in,
    output logic                  read_data_enable,
    output logic                  write_data_enable,
    output logic [9:0]            address_memory_data,
    input  logic [WIDTH_DATA-1:0] result_alu,
    output logic [WIDTH_DATA-1:0] operand_a,
    output logic [WIDTH_DATA-1:0] operand_b,
    output logic [3:0]            op_ALU,
    input  logic                  stack_full_operations,
    input  logic [WIDTH_DATA-1:0] stack_data_out_operations,
    output logic                  stack_push_operations,
    output logic                  stack_pop_operations,
    output logic [WIDTH_DATA-1:0] stack_data_in_operations,
    input  logic                  stack_full_subroutines,
    input  logic [WIDTH_DATA-1:0] stack_data_out_subroutines,
    output logic                  stack_push_subroutines,
    output logic                  stack_pop_subroutines,
    output logic [WIDTH_DATA-1:0] stack_data_in_subroutines
);

    logic [AWIDTH-1:0]     r_pc;
    logic [WIDTH_DATA-1:0] r_ir;
    logic [WIDTH_DATA-1:0] r_operand_a;
    logic [WIDTH_DATA-1:0] r_operand_b;
    state_t                w_state;
    logic [4:0]            w_ir_opc;
    logic [10:0]           w_imm;
    logic                  w_unused_sub;

    assign w_ir_opc     = get_opc(r_ir);
    assign w_imm        = get_imm(r_ir);
    // Only the PC-sized low bits of a return address are meaningful
    assign w_unused_sub = ^stack_data_out_subroutines[WIDTH_DATA-1:AWIDTH];

    assign address_memory_inst = r_pc;
    assign address_memory_data = r_ir[9:0];
    assign operand_a           = r_operand_a;
    assign operand_b           = r_operand_b;
    assign op_ALU              = alu_code(w_ir_opc);

    cpu_control_fsm u_control_fsm (
        .clk                    (clk),
        .reset                  (reset),
        .fetch_opc              (get_opc(instruction)),
        .ir_opc                 (w_ir_opc),
        .stack_full_operations  (stack_full_operations),
        .stack_full_subroutines (stack_full_subroutines),
        .state                  (w_state),
        .read_inst_enable       (read_inst_enable),
        .read_data_enable       (read_data_enable),
        .write_data_enable      (write_data_enable),
        .stack_push_operations  (stack_push_operations),
        .stack_pop_operations   (stack_pop_operations),
        .stack_push_subroutines (stack_push_subroutines),
        .stack_pop_subroutines  (stack_pop_subroutines)
    );

    // Datapath registers: IR/PC load in DECODE, operands latch while popping,
    // control transfers resolve in EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_operand_a <= '0;
            r_operand_b <= '0;
        end else begin
            case (w_state)
                ST_DECODE: begin
                    r_ir <= instruction;
                    r_pc <= r_pc + AWIDTH'(1);
                    if (get_opc(instruction) == c_OPC_NOT) begin
                        r_operand_b <= '0;
                    end
                end
                ST_POP_B: r_operand_b <= stack_data_out_operations;
                ST_POP_A: r_operand_a <= stack_data_out_operations;
                ST_EXEC: begin
                    case (w_ir_opc)
                        c_OPC_GOTO: r_pc <= w_imm[AWIDTH-1:0];
                        c_OPC_IF_Z: begin
                            if (stack_data_out_operations == '0) begin
                                r_pc <= w_imm[AWIDTH-1:0];
                            end
                        end
                        c_OPC_CALL: begin
                            if (!stack_full_subroutines) begin
                                r_pc <= w_imm[AWIDTH-1:0];
                            end
                        end
                        c_OPC_RET:  r_pc <= stack_data_out_subroutines[AWIDTH-1:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Data-path outputs for stack pushes and memory writes, zero when idle
    always_comb begin
        stack_data_in_operations  = '0;
        stack_data_in_subroutines = '0;
        memory_data_out           = '0;
        case (w_state)
            ST_EXEC: begin
                case (w_ir_opc)
                    c_OPC_PUSH_I: stack_data_in_operations  = {{(WIDTH_DATA-11){1'b0}}, w_imm};
                    c_OPC_POP:    memory_data_out           = stack_data_out_operations;
                    c_OPC_CALL:   stack_data_in_subroutines = {{(WIDTH_DATA-AWIDTH){1'b0}}, r_pc};
                    default: ;
                endcase
            end
            ST_PUSH: begin
                stack_data_in_operations = (w_ir_opc == c_OPC_PUSH) ? memory_data_in : result_alu;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu
// Description : Directed self-checking bench for the cpu core with behavioural
//               instruction memory, operand/subroutine stacks and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [4:0]  address_memory_inst;
    logic        read_inst_enable;
    logic [15:0] memory_data_out;
    logic [15:0] memory_data_in;
    logic        read_data_enable;
    logic        write_data_enable;
    logic [9:0]  address_memory_data;
    logic [15:0] result_alu;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  op_ALU;
    logic        stack_full_operations;
    logic [15:0] stack_data_out_operations;
    logic        stack_push_operations;
    logic        stack_pop_operations;
    logic [15:0] stack_data_in_operations;
    logic        stack_full_subroutines;
    logic [15:0] stack_data_out_subroutines;
    logic        stack_push_subroutines;
    logic        stack_pop_subroutines;
    logic [15:0] stack_data_in_subroutines;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] imem [32];
    logic [15:0] ops_mem [16];
    logic [4:0]  ops_sp;
    logic [15:0] sub_mem [16];
    logic [4:0]  sub_sp;

    cpu dut (
        .clk                        (clk),
        .reset                      (reset),
        .instruction                (instruction),
        .address_memory_inst        (address_memory_inst),
        .read_inst_enable           (read_inst_enable),
        .memory_data_out            (memory_data_out),
        .memory_data_in             (memory_data_in),
        .read_data_enable           (read_data_enable),
        .write_data_enable          (write_data_enable),
        .address_memory_data        (address_memory_data),
        .result_alu                 (result_alu),
        .operand_a                  (operand_a),
        .operand_b                  (operand_b),
        .op_ALU                     (op_ALU),
        .stack_full_operations      (stack_full_operations),
        .stack_data_out_operations  (stack_data_out_operations),
        .stack_push_operations      (stack_push_operations),
        .stack_pop_operations       (stack_pop_operations),
        .stack_data_in_operations   (stack_data_in_operations),
        .stack_full_subroutines     (stack_full_subroutines),
        .stack_data_out_subroutines (stack_data_out_subroutines),
        .stack_push_subroutines     (stack_push_subroutines),
        .stack_pop_subroutines      (stack_pop_subroutines),
        .stack_data_in_subroutines  (stack_data_in_subroutines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: address is stable through DECODE, so a direct read suffices
    assign instruction = imem[address_memory_inst];

    assign stack_data_out_operations  = (ops_sp == 5'd0) ? 16'h0000 : ops_mem[4'(ops_sp - 5'd1)];
    assign stack_data_out_subroutines = (sub_sp == 5'd0) ? 16'h0000 : sub_mem[4'(sub_sp - 5'd1)];

    // Operand stack model
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_sp <= 5'd0;
        end else if (stack_push_operations) begin
            ops_mem[4'(ops_sp)] <= stack_data_in_operations;
            ops_sp <= ops_sp + 5'd1;
        end else if (stack_pop_operations) begin
            ops_sp <= ops_sp - 5'd1;
        end
    end

    // Subroutine stack model
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_sp <= 5'd0;
        end else if (stack_push_subroutines) begin
            sub_mem[4'(sub_sp)] <= stack_data_in_subroutines;
            sub_sp <= sub_sp + 5'd1;
        end else if (stack_pop_subroutines) begin
            sub_sp <= sub_sp - 5'd1;
        end
    end

    // Behavioural ALU
    always_comb begin
        result_alu = 16'h0000;
        case (op_ALU)
            4'd0:  result_alu = operand_a + operand_b;
            4'd1:  result_alu = operand_a - operand_b;
            4'd2:  result_alu = operand_a * operand_b;
            4'd3:  result_alu = (operand_b == 16'h0) ? 16'h0 : operand_a / operand_b;
            4'd4:  result_alu = (operand_b == 16'h0) ? 16'h0 : operand_a % operand_b;
            4'd5:  result_alu = operand_a & operand_b;
            4'd6:  result_alu = ~(operand_a & operand_b);
            4'd7:  result_alu = operand_a | operand_b;
            4'd8:  result_alu = operand_a ^ operand_b;
            4'd9:  result_alu = (operand_a == operand_b) ? 16'h1 : 16'h0;
            4'd10: result_alu = ~operand_a;
            default: result_alu = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] strobes();
        return {read_inst_enable, read_data_enable, write_data_enable,
                stack_push_operations, stack_pop_operations,
                stack_push_subroutines, stack_pop_subroutines};
    endfunction

    // Pulse reset, check the reset-state outputs, release into FETCH
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_strobes", 32'(strobes()), 32'h0);
        check("rst_pc", 32'(address_memory_inst), 32'h0);
        check("rst_operands", {operand_a, operand_b}, 32'h0);
        check("rst_op_alu", 32'(op_ALU), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    endtask

    initial begin
        reset                  = 1'b0;
        memory_data_in         = 16'hBEEF;
        stack_full_operations  = 1'b0;
        stack_full_subroutines = 1'b0;

        // ---------------- ALU, memory and branch program ----------------
        clear_imem();
        imem[0]  = 16'h0805; // PUSH_I 5
        imem[1]  = 16'h0802; // PUSH_I 2
        imem[2]  = 16'h2000; // ADD
        imem[3]  = 16'h13FF; // PUSH 0x3FF
        imem[4]  = 16'h1001; // PUSH 0x001
        imem[5]  = 16'h1810; // POP 0x010
        imem[6]  = 16'h800C; // IF_Z 12 (top 0xBEEF)
        imem[7]  = 16'h800C; // IF_Z 12 (top 7)
        imem[8]  = 16'h0800; // PUSH_I 0
        imem[9]  = 16'h800C; // IF_Z 12 (top 0, taken)
        imem[12] = 16'h7814; // GOTO 20
        imem[20] = 16'h0000; // NOP
        imem[21] = 16'hF800; // HALT
        do_reset();
        check("fetch0", {31'(address_memory_inst), read_inst_enable}, {31'd0, 1'b1});
        steps(2);
        check("pushi5", {15'(stack_push_operations), stack_data_in_operations}, {15'd1, 16'd5});
        steps(1);
        check("fetch1", 32'(address_memory_inst), 32'd1);
        steps(2);
        check("pushi2", {15'(stack_push_operations), stack_data_in_operations}, {15'd1, 16'd2});
        steps(1);
        check("fetch2", 32'(address_memory_inst), 32'd2);
        steps(2);
        check("add_pop_b", 32'(strobes()), 32'b0000100);
        steps(1);
        check("add_pop_a", {15'(stack_pop_operations), operand_b}, {15'd1, 16'd2});
        steps(1);
        check("add_operands", {operand_a, operand_b}, {16'd5, 16'd2});
        check("add_op_alu", 32'(op_ALU), 32'd0);
        check("add_push", {15'(stack_push_operations), stack_data_in_operations}, {15'd1, 16'd7});
        steps(1);
        check("add_5cyc_fetch3", {31'(address_memory_inst), read_inst_enable}, {31'd3, 1'b1});
        check("add_stack_top", {11'(ops_sp), stack_data_out_operations}, {11'd1, 16'd7});
        steps(2);
        check("push_mem_rd", {21'(read_data_enable), 1'b0, address_memory_data}, {21'd1, 1'b0, 10'h3FF});
        steps(1);
        check("push_mem_data", {15'(stack_push_operations), stack_data_in_operations}, {15'd1, 16'hBEEF});
        steps(1);
        check("fetch4", 32'(address_memory_inst), 32'd4);
        memory_data_in = 16'h1234;
        steps(3);
        check("push_mem_1234", stack_data_in_operations, 32'h1234);
        steps(1);
        check("fetch5", 32'(address_memory_inst), 32'd5);
        steps(2);
        check("pop_strobes", 32'(strobes()), 32'b0010100);
        check("pop_data", {6'(0), address_memory_data, memory_data_out}, {6'(0), 10'h010, 16'h1234});
        steps(1);
        check("fetch6", 32'(address_memory_inst), 32'd6);
        steps(2);
        check("ifz_pop", 32'(stack_pop_operations), 32'd1);
        steps(1);
        check("ifz_nz_fetch7", 32'(address_memory_inst), 32'd7);
        steps(3);
        check("ifz_nz_fetch8", 32'(address_memory_inst), 32'd8);
        steps(3);
        check("fetch9", 32'(address_memory_inst), 32'd9);
        steps(3);
        check("ifz_taken_fetch12", 32'(address_memory_inst), 32'd12);
        steps(3);
        check("goto_fetch20", 32'(address_memory_inst), 32'd20);
        steps(2);
        check("nop_2cyc_fetch21", {31'(address_memory_inst), read_inst_enable}, {31'd21, 1'b1});
        steps(2);
        check("halt_strobes", 32'(strobes()), 32'h0);
        steps(4);
        check("halt_hold", 32'(strobes()), 32'h0);

        // ---------------- CALL / RET and reset mid-CALL ----------------
        clear_imem();
        imem[0] = 16'hA005; // CALL 5
        imem[5] = 16'hA005; // CALL 5
        imem[6] = 16'hA005; // CALL 5 (aborted by reset)
        do_reset();
        steps(2);
        check("call0_push", {15'(stack_push_subroutines), stack_data_in_subroutines}, {15'd1, 16'd1});
        steps(1);
        check("call0_fetch5", 32'(address_memory_inst), 32'd5);
        check("call0_push_1cyc", 32'(stack_push_subroutines), 32'd0);
        steps(2);
        check("call5_push", {15'(stack_push_subroutines), stack_data_in_subroutines}, {15'd1, 16'd6});
        imem[5] = 16'hA800; // RET
        steps(1);
        check("call5_fetch5", 32'(address_memory_inst), 32'd5);
        steps(2);
        check("ret_pop", 32'(strobes()), 32'b0000001);
        steps(1);
        check("ret_fetch6", {31'(address_memory_inst), read_inst_enable}, {31'd6, 1'b1});
        steps(2);
        check("call6_push", {15'(stack_push_subroutines), stack_data_in_subroutines}, {15'd1, 16'd7});
        #2;
        reset = 1'b0;
        #1;
        check("midcall_strobes", 32'(strobes()), 32'h0);
        check("midcall_pc", 32'(address_memory_inst), 32'h0);
        check("midcall_data", 32'(stack_data_in_subroutines), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midcall_fetch", {31'(address_memory_inst), read_inst_enable}, {31'd0, 1'b1});

        // ---------------- full operand stack ----------------
        clear_imem();
        imem[0] = 16'h0803; // PUSH_I 3
        stack_full_operations = 1'b1;
        do_reset();
        steps(2);
        check("full_no_push", 32'(strobes()), 32'h0);
        steps(1);
        check("full_halt", 32'(read_inst_enable), 32'd0);
        check("full_stack_empty", 32'(ops_sp), 32'd0);
        steps(4);
        check("full_halt_hold", 32'(strobes()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cpu.md
Name: cpu

Overview:
- Multi-cycle, stack-based 16-bit processor core; all storage is external.
- Fetches 16-bit instructions (5-bit opcode + 11-bit immediate) from an external instruction memory.
- Evaluates expressions on an external operand stack using an external combinational ALU.
- Keeps return addresses on a separate external subroutine stack; accesses a 1K-word external data memory.

Parameters:
- WIDTH_DATA, 16, data/instruction/stack word width.
- AWIDTH, 5, program counter and instruction address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  WIDTH_DATA  instruction word; valid the cycle after read_inst_enable.
- address_memory_inst  out  AWIDTH  instruction fetch address (PC).
- read_inst_enable  out  1  instruction read strobe.
- memory_data_out  out  WIDTH_DATA  write data to data memory.
- memory_data_in  in  WIDTH_DATA  read data from data memory; valid the cycle after read_data_enable.
- read_data_enable  out  1  data read strobe.
- write_data_enable  out  1  data write strobe.
- address_memory_data  out  10  data address, equal to imm[9:0].
- result_alu  in  WIDTH_DATA  combinational ALU result.
- operand_a  out  WIDTH_DATA  ALU operand A; deeper stack element.
- operand_b  out  WIDTH_DATA  ALU operand B; top stack element.
- op_ALU  out  4  ALU operation code.
- stack_full_operations  in  1  operand stack full.
- stack_data_out_operations  in  WIDTH_DATA  operand stack top-of-stack; combinational.
- stack_push_operations / stack_pop_operations  out  1  one-cycle push / pop strobes.
- stack_data_in_operations  out  WIDTH_DATA  operand stack push data.
- stack_full_subroutines, stack_data_out_subroutines, stack_push_subroutines, stack_pop_subroutines, stack_data_in_subroutines: same roles for the subroutine stack.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC, IR, operand registers and all outputs go to 0; state goes to FETCH.
  - Reset applied mid-instruction aborts it immediately; no strobe may remain asserted.
- States: FETCH, DECODE, POP_B, POP_A, MEM_RD, PUSH, EXEC, HALT.
- FETCH: read_inst_enable=1, address_memory_inst=PC.
- DECODE: IR<=instruction, PC<=PC+1 (wraps modulo 2^AWIDTH); branch on opcode=IR[15:11], imm=IR[10:0].
- Opcodes and total cycle counts (FETCH+DECODE included):
  - 0 NOP: back to FETCH; 2 cycles.
  - 1 PUSH_I: EXEC pushes zero-extended imm; 3 cycles.
  - 2 PUSH: MEM_RD sets read_data_enable=1, addr=imm[9:0]; then PUSH pushes memory_data_in; 4 cycles.
  - 3 POP: EXEC asserts write_data_enable=1 and stack_pop_operations=1, with memory_data_out=top; 3 cycles.
  - 4-13 binary ALU ops ADD, SUB, MUL, DIV, MOD, AND, NAND, OR, XOR, CMP_EQ (op_ALU = opcode-4, values 0..9):
    - POP_B latches top into operand_b and pops.
    - POP_A latches top into operand_a and pops.
    - PUSH pushes result_alu while operand_a, operand_b and op_ALU are held; 5 cycles.
  - 14 NOT (op_ALU=10): POP_A then PUSH; operand_b=0; 4 cycles.
  - 15 GOTO: EXEC sets PC=imm[AWIDTH-1:0]; 3 cycles.
  - 16 IF_Z: EXEC pops top; if top==0, PC=imm[AWIDTH-1:0]; 3 cycles.
  - 20 CALL: EXEC pushes zero-extended PC (already incremented) to the subroutine stack, PC=imm[AWIDTH-1:0]; 3 cycles.
  - 21 RET: EXEC sets PC=stack_data_out_subroutines[AWIDTH-1:0] and pops the subroutine stack; 3 cycles.
  - 17-19, 22-30 are NOPs.
  - 31 HALT: enter HALT.
- Full-stack handling: any push to a stack whose full flag is 1 is suppressed, and the core enters HALT.
- HALT holds all strobes at 0 until reset.
- Stack strobes are single-cycle; at most one push or pop per stack per cycle.
- Outputs are Moore-decoded from state and registers.
- Stack underflow is not detected; empty stacks return whatever the external stack presents.

Decomposition:
- Shared package: opcode localparams (NOP..HALT), op_ALU codes, state enum, field slices OPC=[15:11] and IMM=[10:0].
- One natural sub-module, cpu_control_fsm: state register, next-state logic and strobe decode.
- Datapath registers (PC, IR, operands) stay in cpu.

Test Plan:
- Reset low mid-CALL → all strobes 0, address_memory_inst=0, state FETCH.
- PUSH_I 5, PUSH_I 2, ADD → pushes 5 then 2; op_ALU=0, operand_a=5, operand_b=2; pushes result_alu (7 from bench ALU); ADD takes 5 cycles.
- CALL 5 at PC=0 → stack_push_subroutines one cycle with data 1, next fetch address 5.
- Second CALL 5 at PC=5 pushes 6; RET with top=6 → pop pulse, next fetch address 6.
- PUSH 0x3FF with memory_data_in=0xBEEF → read_data_enable, address 0x3FF, push 0xBEEF. POP 0x010 with top=0x1234 → write_data_enable, memory_data_out=0x1234, pop pulse.
- PUSH_I with stack_full_operations=1 → no push strobe, core halts; fetch strobe stays 0 thereafter.
